// File: rtl/cmp_bist_pkg.sv
// Shared definitions for the set-less-than BIST engine.
// Holds the FSM state encoding, the directed-vector count, the LFSR
// polynomial/seed and the "no failure seen" marker for first_fail_idx.
package cmp_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIRECTED,
    ST_RANDOM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int          NUM_DIRECTED  = 8;
  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED     = 32'hACE1_2024;
  localparam logic [7:0]  FAIL_IDX_NONE = 8'hFF;

  // One Galois step: shift right, fold the polynomial back in when the
  // bit shifted out was set.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/cmp_bist_lfsr.sv
// 32-bit Galois LFSR that advances two steps per enabled cycle so that
// one operand pair can be produced every clock.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (reloads the seed)
//   load         reload the seed
//   step         advance by two steps
//   rand0/rand1  low OUT_W bits of the first/second step from the
//                current state (the pair the next vector will use)
module cmp_bist_lfsr #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [OUT_W-1:0] rand0,
  output logic [OUT_W-1:0] rand1
);
  import cmp_bist_pkg::*;

  logic [31:0] state_q;
  logic [31:0] step1;
  logic [31:0] step2;

  // Both look-ahead steps are combinational so a vector is ready before
  // the edge that consumes it.
  always_comb begin
    step1 = lfsr_advance(state_q);
    step2 = lfsr_advance(step1);
  end

  // The state only moves when a random vector is actually consumed.
  always_ff @(posedge clk) begin
    if (!rst_n)    state_q <= LFSR_SEED;
    else if (load) state_q <= LFSR_SEED;
    else if (step) state_q <= step2;
  end

  assign rand0 = step1[OUT_W-1:0];
  assign rand1 = step2[OUT_W-1:0];

endmodule

// File: rtl/cmp_bist.sv
// Self-checking stimulus/checker engine for a set-less-than comparator.
// Drives 8 directed corner pairs then NUM_RAND LFSR pairs, one per
// cycle, and checks the DUT result LAT cycles later against a golden
// signed/unsigned compare.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               run request (honoured in IDLE/DONE only)
//   unsigned_mode       compare mode, latched on an accepted start
//   dut_result          comparator output under test
//   operand0/operand1   registered stimulus pair
//   op_valid, busy      live vector / run in progress
//   done, pass          run finished / no mismatches seen
//   err_count           saturating mismatch count
//   first_fail_idx      index of first mismatching vector, FF if none
module cmp_bist #(
  parameter int WIDTH    = 32,
  parameter int NUM_RAND = 16,
  parameter int LAT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             unsigned_mode,
  input  logic [WIDTH-1:0] dut_result,
  output logic [WIDTH-1:0] operand0,
  output logic [WIDTH-1:0] operand1,
  output logic             op_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_fail_idx
);
  import cmp_bist_pkg::*;

  localparam int NUM_VEC = NUM_DIRECTED + NUM_RAND;

  localparam logic [WIDTH-1:0] VAL_ZERO = '0;
  localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] VAL_TWO  = WIDTH'(2);
  localparam logic [WIDTH-1:0] VAL_ONES = '1;
  localparam logic [WIDTH-1:0] VAL_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] VAL_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

  // Corner pairs, returned as {operand0, operand1}.
  function automatic logic [2*WIDTH-1:0] directed_vec(input logic [2:0] k);
    case (k)
      3'd0:    return {VAL_ZERO, VAL_ZERO};
      3'd1:    return {VAL_MIN, VAL_MAX};
      3'd2:    return {VAL_MAX, VAL_MIN};
      3'd3:    return {VAL_ONES, VAL_ONE};
      3'd4:    return {VAL_ONE, VAL_TWO};
      3'd5:    return {VAL_ONES, VAL_ONES};
      3'd6:    return {VAL_MIN, VAL_MIN + VAL_ONE};
      3'd7:    return {VAL_MAX - VAL_ONE, VAL_MAX};
      default: return {VAL_ZERO, VAL_ZERO};
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         idx_q;
  logic [7:0]         nxt_idx;
  logic [1:0]         drain_q;
  logic               mode_q;
  logic               start_ok;
  logic               load_vec;
  logic               lfsr_step;
  logic [2*WIDTH-1:0] next_vec;
  logic [WIDTH-1:0]   rand0, rand1;
  logic               exp_now;
  logic               chk_valid;
  logic               chk_exp;
  logic [7:0]         chk_idx;
  logic               mismatch;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  cmp_bist_lfsr #(.OUT_W(WIDTH)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .step  (lfsr_step),
    .rand0 (rand0),
    .rand1 (rand1)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; empty RANDOM or DRAIN phases are skipped outright.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE:
        if (start) state_d = ST_DIRECTED;
      ST_DIRECTED:
        if (idx_q == 8'(NUM_DIRECTED - 1))
          state_d = (NUM_RAND > 0) ? ST_RANDOM : ((LAT > 0) ? ST_DRAIN : ST_DONE);
      ST_RANDOM:
        if (idx_q == 8'(NUM_VEC - 1))
          state_d = (LAT > 0) ? ST_DRAIN : ST_DONE;
      ST_DRAIN:
        if (drain_q == 2'(LAT - 1)) state_d = ST_DONE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Status outputs are pure functions of the state; pass is only
  // meaningful once done, so it is qualified by it.
  always_comb begin
    op_valid = (state_q == ST_DIRECTED) || (state_q == ST_RANDOM);
    busy     = op_valid || (state_q == ST_DRAIN);
    done     = (state_q == ST_DONE);
    pass     = done && (err_count == 8'd0);
  end

  // Pick the pair to register at the coming edge: vector 0 on start,
  // otherwise the vector after the current one while any remain.
  always_comb begin
    nxt_idx   = idx_q + 8'd1;
    load_vec  = 1'b0;
    lfsr_step = 1'b0;
    next_vec  = directed_vec(3'd0);
    if (start_ok) begin
      load_vec = 1'b1;
    end else if (op_valid && (nxt_idx < 8'(NUM_VEC))) begin
      load_vec = 1'b1;
      if (nxt_idx < 8'(NUM_DIRECTED)) begin
        next_vec = directed_vec(nxt_idx[2:0]);
      end else begin
        next_vec  = {rand0, rand1};
        lfsr_step = 1'b1;
      end
    end
  end

  // Vector index, drain counter, latched mode and operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= 8'd0;
      drain_q  <= 2'd0;
      mode_q   <= 1'b0;
      operand0 <= '0;
      operand1 <= '0;
    end else begin
      if (start_ok) begin
        idx_q  <= 8'd0;
        mode_q <= unsigned_mode;
      end else if (op_valid) begin
        idx_q <= nxt_idx;
      end
      drain_q <= (state_q == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
      if (load_vec) {operand0, operand1} <= next_vec;
    end
  end

  // Golden compare on the pair currently presented to the DUT.
  always_comb begin
    if (mode_q) exp_now = (operand0 < operand1);
    else        exp_now = ($signed(operand0) < $signed(operand1));
  end

  // Expected value and index travel LAT cycles to line up with the DUT.
  if (LAT == 0) begin : g_nopipe
    assign chk_valid = op_valid;
    assign chk_exp   = exp_now;
    assign chk_idx   = idx_q;
  end else begin : g_pipe
    logic [LAT-1:0] pipe_valid;
    logic [LAT-1:0] pipe_exp;
    logic [7:0]     pipe_idx [LAT];

    // Only the valid bits need clearing; data is ignored while invalid.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= op_valid;
        for (int i = 1; i < LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
      end
    end

    // Expected/index payload shifts every cycle alongside the valid bits.
    always_ff @(posedge clk) begin
      pipe_exp[0] <= exp_now;
      pipe_idx[0] <= idx_q;
      for (int i = 1; i < LAT; i++) begin
        pipe_exp[i] <= pipe_exp[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end

    assign chk_valid = pipe_valid[LAT-1];
    assign chk_exp   = pipe_exp[LAT-1];
    assign chk_idx   = pipe_idx[LAT-1];
  end

  // Anything but a clean 0/1 in bit 0 counts as a mismatch.
  assign mismatch = chk_valid &&
                    ((dut_result[0] != chk_exp) || (dut_result[WIDTH-1:1] != '0));

  // Error bookkeeping; a zero count means no mismatch has been seen yet,
  // which identifies the first failure without a separate flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count      <= 8'd0;
      first_fail_idx <= FAIL_IDX_NONE;
    end else if (start_ok) begin
      err_count      <= 8'd0;
      first_fail_idx <= FAIL_IDX_NONE;
    end else if (mismatch) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (err_count == 8'd0)  first_fail_idx <= chk_idx;
    end
  end

endmodule
